// File: rtl/ndp_pkg.sv
// Shared constants for the NDP output stage.
// Lane geometry and the AXIS word width.
package ndp_pkg;

  localparam int WIDTH = 16;
  localparam int NUM_LANES = 64;
  localparam int WORDS = NUM_LANES / 2;
  localparam int SIGN_BIT = WIDTH - 1;
  localparam int AXIS_W = 32;
  localparam logic [WIDTH-1:0] ZERO_LANE = '0;

  // Sign test shared by fp16 and two's-complement lanes.
  function automatic logic lane_neg(
    input logic [WIDTH-1:0] x
  );
    return x[SIGN_BIT];
  endfunction

endpackage

// File: rtl/ndp_relu.sv
// Per-lane ReLU clamp applied at the buffer write port.
// Any lane with its sign bit set becomes zero (incl. -0.0, -NaN).
module ndp_relu
  import ndp_pkg::*;
#(
  parameter int WIDTH = ndp_pkg::WIDTH,
  parameter bit IS_FLOAT = 1'b1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic neg;

  // fp16 and integer lanes both carry the sign in the top bit.
  always_comb begin
    if (IS_FLOAT) neg = d[WIDTH-1];
    else          neg = ($signed(d) < 0);
    q = (en && neg) ? ZERO_LANE : d;
  end

endmodule

// File: rtl/ndp_out_packer.sv
// NDP output stage: 2-slot ping-pong vector buffer feeding
// an AXI4-Stream port, two lanes per 32-bit word.
module ndp_out_packer
  import ndp_pkg::*;
#(
  parameter int WIDTH = ndp_pkg::WIDTH,
  parameter bit IS_FLOAT = 1'b1,
  parameter int NUM_LANES = ndp_pkg::NUM_LANES
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [NUM_LANES*WIDTH-1:0] res_data,
  input  logic                       is_relu_in,
  input  logic                       is_last_in,
  output logic [AXIS_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy
);

  localparam int NW = NUM_LANES / 2;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int VW = NUM_LANES * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  logic [VW-1:0] wr_data;
  logic [VW-1:0] slot_data [2];
  logic [1:0]    slot_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [IW-1:0] word_idx;
  logic          rdy_q;
  logic          push;
  logic          pop;
  logic          pop_end;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_relu
    ndp_relu #(
      .WIDTH    (WIDTH),
      .IS_FLOAT (IS_FLOAT)
    ) u_relu (
      .en (is_relu_in),
      .d  (res_data[i*WIDTH +: WIDTH]),
      .q  (wr_data[i*WIDTH +: WIDTH])
    );
  end

  assign res_ready     = rdy_q;
  assign m_axis_tvalid = (count != 2'd0);
  assign busy          = (count != 2'd0);
  assign m_axis_tdata  =
    slot_data[rd_ptr][int'(word_idx)*AXIS_W +: AXIS_W];
  assign m_axis_tlast  =
    slot_last[rd_ptr] && (word_idx == LAST_IDX);

  // Handshake decode and next occupancy.
  always_comb begin
    push      = res_valid && rdy_q;
    pop       = m_axis_tvalid && m_axis_tready;
    pop_end   = pop && (word_idx == LAST_IDX);
    count_nxt = count;
    if (push && !pop_end)      count_nxt = count + 2'd1;
    else if (!push && pop_end) count_nxt = count - 2'd1;
  end

  // Slot storage: clamped vector and its last flag.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      slot_data[0] <= '0;
      slot_data[1] <= '0;
      slot_last    <= '0;
    end else if (push) begin
      slot_data[wr_ptr] <= wr_data;
      slot_last[wr_ptr] <= is_last_in;
    end
  end

  // Pointers, occupancy, word index and registered ready.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      word_idx <= '0;
      rdy_q    <= 1'b0;
    end else begin
      count <= count_nxt;
      rdy_q <= (count_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop_end) begin
        rd_ptr   <= ~rd_ptr;
        word_idx <= '0;
      end else if (pop) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule
